fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h1000_0000, the first fetch address after reset.
REQ-002 The block SHALL provide parameter DEPTH, default 4, the number of queue entries (legal: 2, 4, 8).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  instruction memory read request, valid this cycle.
REQ-006 The block SHALL have port imem_addr  output  32  word-aligned read address; meaningful only when imem_req=1.
REQ-007 The block SHALL have port imem_rdata  input  32  read data; valid exactly one cycle after the accepting request.
REQ-008 The block SHALL have port redirect  input  1  taken branch or jump from execute; flushes all fetched work.
REQ-009 The block SHALL have port redirect_pc  input  32  target of the redirect.
REQ-010 The block SHALL have port stall  input  1  decode cannot accept an instruction this cycle.
REQ-011 The block SHALL have port instr_valid  output  1  the queue head is presented to decode.
REQ-012 The block SHALL have port instr_out  output  32  head instruction; 32'h0000_0033 (NOP) when instr_valid=0.
REQ-013 The block SHALL have port pc_out  output  32  address of the head instruction; 32'h0 when instr_valid=0.

Function
REQ-014 Internal state SHALL be: fetch_pc (32b), a DEPTH-entry circular {pc, instr} FIFO with read/write pointers and a count (0..DEPTH), an inflight flag, and an inflight_pc register.
REQ-015 imem_req SHALL be 1 iff rst=0 and either (redirect=1) or (count + inflight < DEPTH).
REQ-016 imem_addr SHALL be {redirect_pc[31:2],2'b00} when redirect=1, else fetch_pc; the low two bits of redirect_pc are ignored.
REQ-017 On an issued request, fetch_pc SHALL become imem_addr + 4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0), inflight SHALL become 1, and inflight_pc SHALL capture imem_addr.
REQ-018 When no request is issued, inflight SHALL become 0 and fetch_pc SHALL hold.
REQ-019 When inflight=1 and redirect=0, {inflight_pc, imem_rdata} SHALL be written at the write pointer in that cycle.
REQ-020 Queue data SHALL have no bypass: the earliest instr_valid for a request issued in cycle t is cycle t+2.
REQ-021 instr_valid SHALL equal (count != 0); instr_out and pc_out SHALL come from the read-pointer entry.
REQ-022 Dequeue SHALL occur when instr_valid=1, stall=0 and redirect=0.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-024 By the credit rule of REQ-015, enqueue SHALL never occur at count=DEPTH; an assertion SHALL flag any such occurrence.
REQ-025 redirect=1 SHALL, in the same cycle: drop the returning imem_rdata of any in-flight request, set count to 0, reset both pointers, and issue a request at the redirect target (REQ-016/017).
REQ-026 redirect SHALL take priority over stall, dequeue and enqueue.
REQ-027 While stall=1 and redirect=0, the head entry and outputs SHALL hold, and fetching SHALL continue until count + inflight = DEPTH.

Reset
REQ-028 While rst=1: imem_req=0, instr_valid=0, instr_out=32'h0000_0033, pc_out=0, count=0, pointers=0, inflight=0, fetch_pc=RESET_PC; redirect and stall are ignored.
REQ-029 rst asserted mid-operation SHALL discard all queued and in-flight instructions; the imem_rdata that returns in the cycle after reset deassertion SHALL NOT be enqueued.
REQ-030 In the first cycle after rst deasserts, the block SHALL issue imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-031 Release reset with a memory returning word=address and stall=0 -> req at 1000_0000 in cycle 0; instr_valid=1 in cycle 2 with pc_out=1000_0000; then one instruction per cycle at +4.
REQ-032 Hold stall=1 from cycle 0 -> exactly DEPTH requests (1000_0000..1000_000C); imem_req=0 thereafter; head stays 1000_0000; release stall -> four in-order dequeues, then fetching resumes at 1000_0010.
REQ-033 Assert redirect with redirect_pc=2000_0042 while 3 entries are queued and a request is in flight -> same-cycle imem_addr=2000_0040; next cycle instr_valid=0; stale data not enqueued; following cycle pc_out=2000_0040.
REQ-034 Assert redirect and stall in the same cycle -> redirect wins: queue empties, request issued at the target.
REQ-035 Redirect to FFFF_FFF8 with stall=0 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Assert rst for one cycle while the queue is full -> following cycle instr_valid=0, imem_req=1 at 1000_0000; no pre-reset instruction is ever presented.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch unit that streams word-aligned reads to instruction
//   memory and buffers the returned words, each with its PC, in a small
//   circular queue that decode drains. A credit rule keeps outstanding
//   requests plus queued entries from exceeding DEPTH. A redirect from
//   execute flushes all fetched work and restarts fetch at the target.
//
//   Parameters
//     RESET_PC     first fetch address after reset
//     DEPTH        number of queue entries (2, 4 or 8)
//
//   Ports
//     clk          single clock, all state updates on its rising edge
//     rst          synchronous, active-high reset
//     imem_req     read request to instruction memory, valid this cycle
//     imem_addr    word-aligned read address (meaningful when imem_req=1)
//     imem_rdata   read data, returned one cycle after the accepted request
//     redirect     taken branch / jump; flushes queue and in-flight read
//     redirect_pc  redirect target (low two bits ignored)
//     stall        decode cannot accept an instruction this cycle
//     instr_valid  queue head is presented to decode
//     instr_out    head instruction, NOP (32'h0000_0033) when not valid
//     pc_out       head instruction address, 0 when not valid
// -----------------------------------------------------------------------------

// Checker: the credit rule must make an enqueue into a full queue impossible.
module fetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic i_enq,
  input logic i_full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_enq && i_full));
endmodule

module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic [31:0]      r_fetch_pc;
  logic             r_inflight;
  logic [31:0]      r_inflight_pc;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [31:0]      r_instr_mem [DEPTH];

  logic [CNT_W:0]   w_occ;
  logic [31:0]      w_addr;
  logic             w_req;
  logic             w_valid;
  logic             w_enq;
  logic             w_deq;
  logic             w_full;

  // Request, enqueue and dequeue decisions.
  always_comb begin
    // Credits in use: queued entries plus the one read that may be returning.
    w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    w_addr  = redirect ? {redirect_pc[31:2], 2'b00} : r_fetch_pc;
    w_req   = !rst && (redirect || (w_occ < {1'b0, FULL_CNT}));
    // Outputs are forced idle during reset even before the state clears.
    w_valid = !rst && (r_count != {CNT_W{1'b0}});
    // A redirect drops whatever data returns in the same cycle.
    w_enq   = !rst && r_inflight && !redirect;
    w_deq   = w_valid && !stall && !redirect;
    w_full  = (r_count == FULL_CNT);
  end

  // Drive the memory interface and the head-of-queue outputs.
  always_comb begin
    imem_req    = w_req;
    imem_addr   = w_addr;
    instr_valid = w_valid;
    if (w_valid) begin
      instr_out = r_instr_mem[r_rd_ptr];
      pc_out    = r_pc_mem[r_rd_ptr];
    end else begin
      instr_out = NOP;
      pc_out    = 32'h0000_0000;
    end
  end

  // Fetch PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
    end else if (w_req) begin
      // 32-bit add wraps FFFF_FFFC -> 0000_0000.
      r_fetch_pc    <= w_addr + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_addr;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  // Queue pointers and occupancy; redirect outranks enqueue and dequeue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (redirect) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  fetch_queue_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .i_enq  (w_enq),
    .i_full (w_full)
  );

endmodule
